// File: rtl/fwd_pipe_ctrl.sv
// fwd_pipe_ctrl: tracks in-flight register writes between execute and
// register-file commit, forwards the youngest producer to each source
// operand, stalls issue on load-use hazards, drives the register-file write
// port and keeps saturating stall/forward performance counters.
//
// Stage 0 is the youngest entry; stage STAGES-1 commits. A load enters with
// ready=0 and picks up mem_data as it leaves MEM_STAGE, so only stages below
// MEM_STAGE can ever hold an unready entry that nobody can forward.
module fwd_pipe_ctrl #(
    parameter int DBITS               = 32,
    parameter int REG_INDEX_BIT_WIDTH = 4,
    parameter int STAGES              = 3,
    parameter int MEM_STAGE           = 1,
    parameter int NUM_SRC             = 2,
    parameter int ZERO_REG_HARDWIRED  = 0,
    parameter int CNT_BITS            = 16
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   issue_valid,
    input  logic                                   flush,
    input  logic                                   issue_regWrite,
    input  logic [REG_INDEX_BIT_WIDTH-1:0]         issue_dstReg,
    input  logic [DBITS-1:0]                       issue_data,
    input  logic                                   issue_dataReady,
    input  logic [DBITS-1:0]                       mem_data,
    input  logic [NUM_SRC*REG_INDEX_BIT_WIDTH-1:0] src_reg,
    input  logic [NUM_SRC*DBITS-1:0]               src_rf_data,
    output logic [NUM_SRC*DBITS-1:0]               src_data,
    output logic                                   stall,
    output logic                                   wb_en,
    output logic [REG_INDEX_BIT_WIDTH-1:0]         wb_reg,
    output logic [DBITS-1:0]                       wb_data,
    output logic [CNT_BITS-1:0]                    stall_cnt,
    output logic [CNT_BITS-1:0]                    fwd_cnt
);

    localparam int RW   = REG_INDEX_BIT_WIDTH;
    localparam int LAST = STAGES - 1;

    logic [STAGES-1:0] st_valid;
    logic [STAGES-1:0] st_regw;
    logic [STAGES-1:0] st_ready;
    logic [RW-1:0]     st_dst  [STAGES];
    logic [DBITS-1:0]  st_data [STAGES];

    logic [NUM_SRC-1:0] op_hazard;
    logic [NUM_SRC-1:0] op_fwd;
    logic               any_hazard;
    logic               any_fwd;
    logic               accept;

    // Operand forwarding: scan oldest to youngest so the youngest match wins.
    always_comb begin
        src_data  = src_rf_data;
        op_hazard = '0;
        op_fwd    = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            for (int k = STAGES - 1; k >= 0; k--) begin
                if (st_valid[k] && st_regw[k] &&
                    (st_dst[k] == src_reg[i*RW +: RW]) &&
                    !((ZERO_REG_HARDWIRED != 0) && (src_reg[i*RW +: RW] == '0))) begin
                    if (st_ready[k]) begin
                        src_data[i*DBITS +: DBITS] = st_data[k];
                        op_fwd[i]                  = 1'b1;
                        op_hazard[i]               = 1'b0;
                    end else if (k == MEM_STAGE) begin
                        src_data[i*DBITS +: DBITS] = mem_data;
                        op_fwd[i]                  = 1'b1;
                        op_hazard[i]               = 1'b0;
                    end else begin
                        // Load still upstream of the memory stage: nothing to forward yet.
                        src_data[i*DBITS +: DBITS] = src_rf_data[i*DBITS +: DBITS];
                        op_fwd[i]                  = 1'b0;
                        op_hazard[i]               = 1'b1;
                    end
                end
            end
        end
    end

    // Issue control: flush overrides a hazard, so a flushed issue never stalls.
    always_comb begin
        any_hazard = |op_hazard;
        any_fwd    = |op_fwd;
        stall      = issue_valid & ~flush & any_hazard;
        accept     = issue_valid & ~flush & ~any_hazard;
    end

    // Commit port reads the oldest stage directly. If the memory stage is also
    // the commit stage, an unready load commits with the arriving mem_data.
    always_comb begin
        wb_en  = st_valid[LAST] & st_regw[LAST];
        wb_reg = st_dst[LAST];
        if ((MEM_STAGE == LAST) && !st_ready[LAST])
            wb_data = mem_data;
        else
            wb_data = st_data[LAST];
    end

    // Valid bits: a reset empties the pipe so nothing in flight ever commits.
    always_ff @(posedge clk) begin
        if (!reset) begin
            st_valid <= '0;
        end else begin
            st_valid[0] <= accept;
            for (int k = 1; k < STAGES; k++)
                st_valid[k] <= st_valid[k-1];
        end
    end

    // Payload shift; a load leaving the memory stage captures mem_data.
    always_ff @(posedge clk) begin
        st_regw[0]  <= issue_regWrite;
        st_dst[0]   <= issue_dstReg;
        st_data[0]  <= issue_data;
        st_ready[0] <= issue_dataReady;
        for (int k = 1; k < STAGES; k++) begin
            st_regw[k] <= st_regw[k-1];
            st_dst[k]  <= st_dst[k-1];
            if ((k - 1 == MEM_STAGE) && !st_ready[k-1]) begin
                st_data[k]  <= mem_data;
                st_ready[k] <= 1'b1;
            end else begin
                st_data[k]  <= st_data[k-1];
                st_ready[k] <= st_ready[k-1];
            end
        end
    end

    // Saturating performance counters.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stall_cnt <= '0;
            fwd_cnt   <= '0;
        end else begin
            if (stall && (stall_cnt != '1))
                stall_cnt <= stall_cnt + CNT_BITS'(1);
            if (accept && any_fwd && (fwd_cnt != '1))
                fwd_cnt <= fwd_cnt + CNT_BITS'(1);
        end
    end

endmodule

// File: tb/tb_fwd_pipe_ctrl.sv
// Bench for fwd_pipe_ctrl: two instances share one stimulus stream.
// Instance a uses defaults; instance b has 4-bit counters and a hardwired r0.
// A queue-based model of in-flight instructions (tracked by age) is checked
// against both instances every cycle, alongside hand-computed expectations.
module tb_fwd_pipe_ctrl;

    localparam int STAGES    = 3;
    localparam int MEM_STAGE = 1;
    localparam logic [31:0] RF0 = 32'hAAAA_0000;
    localparam logic [31:0] RF1 = 32'hBBBB_0001;

    logic        clk = 1'b0;
    logic        reset;
    logic        issue_valid, flush, issue_regWrite, issue_dataReady;
    logic [3:0]  issue_dstReg;
    logic [31:0] issue_data, mem_data;
    logic [7:0]  src_reg;
    logic [63:0] src_rf_data;

    logic [63:0] sd_a, sd_b;
    logic        st_a, st_b, we_a, we_b;
    logic [3:0]  wr_a, wr_b;
    logic [31:0] wd_a, wd_b;
    logic [15:0] sc_a, fc_a;
    logic [3:0]  sc_b, fc_b;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_on = 0;

    always #5 clk = ~clk;

    fwd_pipe_ctrl u_a (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .flush(flush),
        .issue_regWrite(issue_regWrite), .issue_dstReg(issue_dstReg),
        .issue_data(issue_data), .issue_dataReady(issue_dataReady),
        .mem_data(mem_data), .src_reg(src_reg), .src_rf_data(src_rf_data),
        .src_data(sd_a), .stall(st_a), .wb_en(we_a), .wb_reg(wr_a),
        .wb_data(wd_a), .stall_cnt(sc_a), .fwd_cnt(fc_a)
    );

    fwd_pipe_ctrl #(.CNT_BITS(4), .ZERO_REG_HARDWIRED(1)) u_b (
        .clk(clk), .reset(reset), .issue_valid(issue_valid), .flush(flush),
        .issue_regWrite(issue_regWrite), .issue_dstReg(issue_dstReg),
        .issue_data(issue_data), .issue_dataReady(issue_dataReady),
        .mem_data(mem_data), .src_reg(src_reg), .src_rf_data(src_rf_data),
        .src_data(sd_b), .stall(st_b), .wb_en(we_b), .wb_reg(wr_b),
        .wb_data(wd_b), .stall_cnt(sc_b), .fwd_cnt(fc_b)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- model: instructions in flight, by age ----------------
    typedef struct {
        int          inst;
        bit          rw;
        logic [3:0]  dst;
        logic [31:0] data;
        bit          ld;    // data not yet known (load before memory stage)
        int          age;   // cycles since accepted; equals its stage number
    } ent_t;

    ent_t q[$];
    int   m_sc[2];
    int   m_fc[2];
    int   cmax[2] = '{65535, 15};
    bit   zh[2]   = '{1'b0, 1'b1};

    function automatic void eval(input int n, output logic [63:0] sd,
                                 output bit [1:0] hz, output bit st, output bit af,
                                 output bit we, output logic [3:0] wr,
                                 output logic [31:0] wd);
        sd = src_rf_data; hz = '0; af = 0; we = 0; wr = '0; wd = '0;
        for (int i = 0; i < 2; i++) begin
            logic [3:0] s;
            int best;
            s = src_reg[i*4 +: 4];
            best = -1;
            foreach (q[j])
                if (q[j].inst == n && q[j].rw && q[j].dst == s && !(zh[n] && s == 4'd0))
                    if (best < 0 || q[j].age < q[best].age) best = j;
            if (best >= 0) begin
                if (!q[best].ld) begin
                    sd[i*32 +: 32] = q[best].data; af = 1;
                end else if (q[best].age == MEM_STAGE) begin
                    sd[i*32 +: 32] = mem_data; af = 1;
                end else begin
                    hz[i] = 1;
                end
            end
        end
        st = issue_valid && !flush && (hz != 2'b00);
        foreach (q[j])
            if (q[j].inst == n && q[j].age == STAGES - 1) begin
                we = q[j].rw; wr = q[j].dst;
                wd = q[j].ld ? mem_data : q[j].data;
            end
    endfunction

    // Per-cycle compare against the model, then advance the model.
    always @(negedge clk) begin
        logic [63:0] esd;
        bit [1:0]    ehz;
        bit          est, eaf, ewe;
        logic [3:0]  ewr;
        logic [31:0] ewd;
        bit [1:0]    st_m, af_m;
        for (int n = 0; n < 2; n++) begin
            eval(n, esd, ehz, est, eaf, ewe, ewr, ewd);
            st_m[n] = est;
            af_m[n] = eaf;
            if (chk_on) begin
                for (int i = 0; i < 2; i++)
                    if (!ehz[i])
                        chk($sformatf("src_data%0d_%0d", i, n),
                            n == 1 ? sd_b[i*32 +: 32] : sd_a[i*32 +: 32], esd[i*32 +: 32]);
                chk($sformatf("stall_%0d", n), n == 1 ? st_b : st_a, est);
                chk($sformatf("wb_en_%0d", n), n == 1 ? we_b : we_a, ewe);
                if (ewe) begin
                    chk($sformatf("wb_reg_%0d", n), n == 1 ? wr_b : wr_a, ewr);
                    chk($sformatf("wb_data_%0d", n), n == 1 ? wd_b : wd_a, ewd);
                end
                chk($sformatf("stall_cnt_%0d", n), n == 1 ? longint'(sc_b) : longint'(sc_a), m_sc[n]);
                chk($sformatf("fwd_cnt_%0d", n), n == 1 ? longint'(fc_b) : longint'(fc_a), m_fc[n]);
            end
        end
        if (!reset) begin
            q.delete();
            m_sc = '{0, 0};
            m_fc = '{0, 0};
        end else begin
            foreach (q[j]) begin
                if (q[j].ld && q[j].age == MEM_STAGE) begin
                    q[j].data = mem_data;
                    q[j].ld   = 0;
                end
                q[j].age = q[j].age + 1;
            end
            for (int j = q.size() - 1; j >= 0; j--)
                if (q[j].age >= STAGES) q.delete(j);
            for (int n = 0; n < 2; n++) begin
                bit acc;
                acc = issue_valid && !flush && !st_m[n];
                if (st_m[n] && m_sc[n] < cmax[n]) m_sc[n]++;
                if (acc && af_m[n] && m_fc[n] < cmax[n]) m_fc[n]++;
                if (acc)
                    q.push_back('{inst: n, rw: issue_regWrite, dst: issue_dstReg,
                                  data: issue_data, ld: !issue_dataReady, age: 0});
            end
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic drv(input bit v, input bit fl, input bit rw, input logic [3:0] dst,
                       input logic [31:0] d, input bit rdy, input logic [3:0] s0,
                       input logic [3:0] s1, input logic [31:0] m);
        issue_valid = v; flush = fl; issue_regWrite = rw; issue_dstReg = dst;
        issue_data = d; issue_dataReady = rdy; src_reg = {s1, s0}; mem_data = m;
    endtask

    task automatic idle();
        drv(0, 0, 0, 4'd0, 32'h0, 1, 4'd5, 4'd6, 32'h0);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        src_rf_data = {RF1, RF0};
        reset = 1'b0;
        idle();
        tick();
        tick();
        reset = 1'b1;
        chk_on = 1;
        #1;
        chk("rst_wb_en", we_a, 0);
        chk("rst_stall", st_a, 0);
        chk("rst_stall_cnt", sc_a, 0);
        chk("rst_fwd_cnt", fc_a, 0);
        tick();

        // ALU chain
        drv(1, 0, 1, 4'd1, 32'h11, 1, 4'd5, 4'd6, 32'h0); tick();
        drv(1, 0, 0, 4'd0, 32'h0, 1, 4'd1, 4'd6, 32'h0); #1;
        chk("alu_fwd", sd_a[31:0], 32'h11);
        chk("alu_nostall", st_a, 0);
        tick();
        idle(); #1;
        chk("alu_fwd_cnt", fc_a, 1);
        tick();
        idle(); #1;
        chk("alu_wb_en", we_a, 1);
        chk("alu_wb_reg", wr_a, 1);
        chk("alu_wb_data", wd_a, 32'h11);
        tick();

        // Load-use
        drv(1, 0, 1, 4'd2, 32'hDEAD, 0, 4'd5, 4'd6, 32'h0); tick();
        drv(1, 0, 0, 4'd0, 32'h0, 1, 4'd2, 4'd6, 32'h1234); #1;
        chk("lu_stall", st_a, 1);
        tick();
        drv(1, 0, 0, 4'd0, 32'h0, 1, 4'd2, 4'd6, 32'hCAFE); #1;
        chk("lu_nostall", st_a, 0);
        chk("lu_memfwd", sd_a[31:0], 32'hCAFE);
        tick();
        idle(); #1;
        chk("lu_stall_cnt", sc_a, 1);
        chk("lu_fwd_cnt", fc_a, 2);
        chk("lu_wb_reg", wr_a, 2);
        chk("lu_wb_data", wd_a, 32'hCAFE);
        tick();

        // Youngest wins, commits in order
        drv(1, 0, 1, 4'd3, 32'h1, 1, 4'd5, 4'd6, 32'h0); tick();
        drv(1, 0, 1, 4'd3, 32'h2, 1, 4'd5, 4'd6, 32'h0); tick();
        drv(1, 0, 0, 4'd0, 32'h0, 1, 4'd3, 4'd3, 32'h0); #1;
        chk("yw_src0", sd_a[31:0], 32'h2);
        chk("yw_src1", sd_a[63:32], 32'h2);
        tick();
        idle(); #1;
        chk("yw_wb1_reg", wr_a, 3);
        chk("yw_wb1_data", wd_a, 32'h1);
        chk("yw_fwd_cnt", fc_a, 3);
        tick();
        idle(); #1;
        chk("yw_wb2_data", wd_a, 32'h2);
        tick();

        // Flush during a load-use hazard
        drv(1, 0, 1, 4'd4, 32'h0, 0, 4'd5, 4'd6, 32'h0); tick();
        drv(1, 1, 0, 4'd0, 32'h0, 1, 4'd4, 4'd6, 32'h0); #1;
        chk("fl_nostall", st_a, 0);
        tick();
        idle(); #1;
        chk("fl_stall_cnt", sc_a, 1);
        tick();

        // Register 0: forwarded on a, hardwired on b
        drv(1, 0, 1, 4'd0, 32'h55, 1, 4'd5, 4'd6, 32'h0); tick();
        drv(1, 0, 0, 4'd0, 32'h0, 1, 4'd0, 4'd5, 32'h0); #1;
        chk("r0_fwd_a", sd_a[31:0], 32'h55);
        chk("r0_rf_b", sd_b[31:0], RF0);
        tick();
        idle(); #1;
        chk("r0_fwd_cnt_a", fc_a, 4);
        chk("r0_fwd_cnt_b", fc_b, 3);
        tick();

        // Reset with three entries in flight
        drv(1, 0, 1, 4'd5, 32'h5, 1, 4'd8, 4'd9, 32'h0); tick();
        drv(1, 0, 1, 4'd6, 32'h6, 1, 4'd8, 4'd9, 32'h0); tick();
        drv(1, 0, 1, 4'd7, 32'h7, 1, 4'd8, 4'd9, 32'h0); tick();
        idle(); reset = 1'b0; tick();
        reset = 1'b1; #1;
        chk("mr_wb_en0", we_a, 0);
        chk("mr_stall_cnt", sc_a, 0);
        chk("mr_fwd_cnt", fc_a, 0);
        chk("mr_stall_cnt_b", sc_b, 0);
        tick();
        #1; chk("mr_wb_en1", we_a, 0);
        tick();
        #1; chk("mr_wb_en2", we_a, 0);
        tick();

        // Back-to-back dependent loads: stalls every other cycle
        for (int n = 0; n < 41; n++) begin
            drv(1, 0, 1, 4'd2, 32'h0, 0, 4'd2, 4'd8, 32'h77);
            tick();
        end
        idle(); #1;
        chk("sat_stall_cnt_a", sc_a, 20);
        chk("sat_stall_cnt_b", sc_b, 4'hF);
        chk("sat_fwd_cnt_a", fc_a, 20);
        chk("sat_fwd_cnt_b", fc_b, 4'hF);
        tick();
        tick();
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
